ac97_pcm_link: RTL and testbench

AC97_PCM_LINK -- requirements
Module: ac97_pcm_link

---
 rtl/ac97_pkg.sv | 36 +++
 rtl/ac97_pcm_link_if.sv | 36 +++
 rtl/ac97_frame_fifo.sv | 59 +++++
 rtl/ac97_pcm_link.sv | 189 ++++++++++++++++++
 tb/tb_ac97_pcm_link.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ac97_pkg.sv
// AC'97 link constants: frame geometry, tag positions, slot map
// and command field widths shared by the PCM link RTL.
package ac97_pkg;

  localparam int FRAME_BITS   = 256;
  localparam int TAG_BITS     = 16;
  localparam int SLOT_W       = 20;
  localparam int CMD_ADDR_W   = 7;
  localparam int CMD_DATA_W   = 16;
  localparam int CMD_ADDR_PAD = 12;
  localparam int CMD_DATA_PAD = 4;
  localparam int MAX_CH       = 6;

  // channel -> slot; 2ch uses the first two, 4ch the first four
  localparam int SLOT_MAP [MAX_CH] = '{3, 4, 7, 8, 6, 9};

  localparam logic [7:0] LOAD_BIT   = 8'd255;
  localparam logic [7:0] SYNC_END   = 8'd15;
  localparam logic [7:0] STATUS_END = 8'd55;

  typedef struct packed {
    logic                  rd;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

  // frame bit k lives at vector index FRAME_BITS-1-k
  function automatic logic [7:0] tag_idx(input int slot);
    return 8'(FRAME_BITS - 1 - slot);
  endfunction

  function automatic logic [7:0] slot_msb(input int slot);
    return 8'(FRAME_BITS - 1 - TAG_BITS - SLOT_W * (slot - 1));
  endfunction

endpackage

// File: rtl/ac97_pcm_link_if.sv
// Host-side handshake bundle of the AC'97 PCM link:
// PCM frame stream, codec register commands and status responses.
interface ac97_pcm_link_if #(
  parameter int SAMPLE_W = 16,
  parameter int NUM_CH   = 2
);

  logic                       pcm_valid;
  logic                       pcm_ready;
  logic [NUM_CH*SAMPLE_W-1:0] pcm_data;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;

  logic        rsp_valid;
  logic [6:0]  rsp_addr;
  logic [15:0] rsp_data;

  modport master (
    output pcm_valid, pcm_data,
    output cmd_valid, cmd_rd, cmd_addr, cmd_data,
    input  pcm_ready, cmd_ready,
    input  rsp_valid, rsp_addr, rsp_data
  );

  modport slave (
    input  pcm_valid, pcm_data,
    input  cmd_valid, cmd_rd, cmd_addr, cmd_data,
    output pcm_ready, cmd_ready,
    output rsp_valid, rsp_addr, rsp_data
  );

endinterface

// File: rtl/ac97_frame_fifo.sv
// Synchronous FIFO holding one multi-channel PCM frame per entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module ac97_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_pop  = pop && !empty;
  // at full, a same-cycle pop frees the entry this push takes
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/ac97_pcm_link.sv
// AC'97 controller link: PCM/command frame serializer and codec input capture.
// Define AC97_STATUS_CAPTURE_EN to build the slot 1/2 status response path.
module ac97_pcm_link
  import ac97_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            ac97_bitclk,
  input  logic            rst,
  input  logic            ac97_sdata_in,
  output logic            ac97_sdata_out,
  output logic            ac97_sync,
  output logic            ac97_reset_b,
  ac97_pcm_link_if.slave  bus,
  output logic            codec_ready,
  output logic [15:0]     underrun_cnt,
  output logic            frame_strobe
);

  localparam int PCM_W = NUM_CH * SAMPLE_W;

  logic [7:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] new_frame;
  logic                  sdata_out_q, sdata_out_d;
  logic                  sync_q, sync_d;
  logic                  reset_b_q, reset_b_d;
  logic                  strobe_q, strobe_d;
  logic                  codec_ready_q, codec_ready_d;
  logic [15:0]           underrun_q, underrun_d;
  logic                  held_q, held_d;
  cmd_t                  cmd_q, cmd_d;

  logic             load;
  logic             cmd_acc;
  logic             fifo_full, fifo_empty;
  logic [PCM_W-1:0] fifo_dout;

  assign load    = bit_cnt_q == LOAD_BIT;
  assign cmd_acc = bus.cmd_valid && !held_q;

  ac97_frame_fifo #(
    .WIDTH (PCM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ac97_bitclk),
    .rst   (rst),
    .push  (bus.pcm_valid),
    .pop   (load),
    .din   (bus.pcm_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  function automatic logic [SLOT_W-1:0] justify(
    input logic [SAMPLE_W-1:0] s
  );
    return SLOT_W'(s) << (SLOT_W - SAMPLE_W);
  endfunction

  always_comb begin
    new_frame = '0;
    new_frame[FRAME_BITS-1] = 1'b1;
    if (held_q) begin
      new_frame[tag_idx(1)] = 1'b1;
      new_frame[tag_idx(2)] = 1'b1;
      new_frame[slot_msb(1) -: SLOT_W] =
        {cmd_q.rd, cmd_q.addr, {CMD_ADDR_PAD{1'b0}}};
      new_frame[slot_msb(2) -: SLOT_W] = cmd_q.rd ? '0 :
        {cmd_q.data, {CMD_DATA_PAD{1'b0}}};
    end
    if (!fifo_empty) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        new_frame[tag_idx(SLOT_MAP[ch])] = 1'b1;
        new_frame[slot_msb(SLOT_MAP[ch]) -: SLOT_W] =
          justify(fifo_dout[ch*SAMPLE_W +: SAMPLE_W]);
      end
    end
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q + 8'd1;
    shreg_d       = load ? new_frame
                         : {shreg_q[FRAME_BITS-2:0], 1'b0};
    sdata_out_d   = shreg_q[FRAME_BITS-1];
    sync_d        = load || (bit_cnt_q <= SYNC_END);
    strobe_d      = bit_cnt_d == 8'd0;
    reset_b_d     = 1'b1;
    codec_ready_d = (bit_cnt_q == 8'd0) ? ac97_sdata_in
                                        : codec_ready_q;
    underrun_d    = underrun_q;
    if (load && fifo_empty && underrun_q != 16'hFFFF)
      underrun_d = underrun_q + 16'd1;
    held_d = held_q;
    cmd_d  = cmd_q;
    // a command arriving on the load cycle rides the next frame
    if (load && held_q) begin
      held_d = 1'b0;
    end else if (cmd_acc) begin
      held_d = 1'b1;
      cmd_d  = '{rd: bus.cmd_rd, addr: bus.cmd_addr,
                 data: bus.cmd_data};
    end
  end

  always_ff @(posedge ac97_bitclk) begin
    if (rst) begin
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      sdata_out_q   <= 1'b0;
      sync_q        <= 1'b0;
      reset_b_q     <= 1'b0;
      strobe_q      <= 1'b0;
      codec_ready_q <= 1'b0;
      underrun_q    <= '0;
      held_q        <= 1'b0;
      cmd_q         <= '0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      sdata_out_q   <= sdata_out_d;
      sync_q        <= sync_d;
      reset_b_q     <= reset_b_d;
      strobe_q      <= strobe_d;
      codec_ready_q <= codec_ready_d;
      underrun_q    <= underrun_d;
      held_q        <= held_d;
      cmd_q         <= cmd_d;
    end
  end

  assign ac97_sdata_out = sdata_out_q;
  assign ac97_sync      = sync_q;
  assign ac97_reset_b   = reset_b_q;
  assign frame_strobe   = strobe_q;
  assign codec_ready    = codec_ready_q;
  assign underrun_cnt   = underrun_q;
  assign bus.pcm_ready  = !fifo_full;
  assign bus.cmd_ready  = !held_q;

`ifdef AC97_STATUS_CAPTURE_EN
  logic [54:0] in_sh_q;
  logic [55:0] in_sh_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [6:0]  rsp_addr_q, rsp_addr_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        hit;
  logic        unused_status;

  // in_sh_d index 55-k holds input frame bit k at bit 55
  always_comb begin
    in_sh_d     = {in_sh_q, ac97_sdata_in};
    hit         = (bit_cnt_q == STATUS_END)
                  && in_sh_d[54] && in_sh_d[53];
    rsp_valid_d = hit;
    rsp_addr_d  = hit ? in_sh_d[38:32] : rsp_addr_q;
    rsp_data_d  = hit ? in_sh_d[19:4]  : rsp_data_q;
  end

  assign unused_status = ^{in_sh_d[55], in_sh_d[52:39],
                           in_sh_d[31:20], in_sh_d[3:0]};

  always_ff @(posedge ac97_bitclk) begin
    if (rst) begin
      in_sh_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      in_sh_q     <= in_sh_d[54:0];
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = rsp_data_q;
`else
  assign bus.rsp_valid = 1'b0;
  assign bus.rsp_addr  = '0;
  assign bus.rsp_data  = '0;
`endif

endmodule

// File: tb/tb_ac97_pcm_link.sv
// Directed bench for ac97_pcm_link (2ch, 16-bit, 4-deep FIFO).
// Frames are captured bit-serially, aligned to frame_strobe.
module tb_ac97_pcm_link;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdi = 1'b1;
  logic        sdo, sync, rstb, cready, fs;
  logic [15:0] ucnt;

  int tests = 0;
  int fails = 0;

  logic [0:255] fr;
  logic [0:255] in_frame;
  int           rsp_pulses;
  logic [6:0]   rsp_a;
  logic [15:0]  rsp_d;
  logic         sync_ok;

  ac97_pcm_link_if #(.SAMPLE_W(16), .NUM_CH(2)) bus ();

  ac97_pcm_link #(
    .SAMPLE_W   (16),
    .NUM_CH     (2),
    .FIFO_DEPTH (4)
  ) dut (
    .ac97_bitclk    (clk),
    .rst            (rst),
    .ac97_sdata_in  (sdi),
    .ac97_sdata_out (sdo),
    .ac97_sync      (sync),
    .ac97_reset_b   (rstb),
    .bus            (bus),
    .codec_ready    (cready),
    .underrun_cnt   (ucnt),
    .frame_strobe   (fs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:255] mk_in(input logic [15:0] tag,
                                         input logic [19:0] s1,
                                         input logic [19:0] s2);
    logic [0:255] f;
    f        = '0;
    f[0:15]  = tag;
    f[16:35] = s1;
    f[36:55] = s2;
    return f;
  endfunction

  function automatic logic [15:0] tag_of(input logic [0:255] f);
    return f[0:15];
  endfunction

  function automatic logic [19:0] slot_of(input logic [0:255] f,
                                          input int s);
    return f[16 + 20*(s-1) +: 20];
  endfunction

  // advance at least one cycle, then stop on the next strobe
  task automatic wait_strobe(input string tag);
    int n = 0;
    @(negedge clk);
    while (!fs && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(fs), 32'd1);
  endtask

  // called on a strobe cycle; ends on the following strobe cycle
  task automatic capture();
    rsp_pulses = 0;
    sync_ok    = 1'b1;
    sdi        = in_frame[0];
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      fr[k] = sdo;
      if (sync !== ((k < 16) || (k == 255))) sync_ok = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        rsp_pulses++;
        rsp_a = bus.rsp_addr;
        rsp_d = bus.rsp_data;
      end
      if (k < 255) sdi = in_frame[k+1];
    end
    sdi = 1'b1;
  endtask

  initial begin
    bus.pcm_valid = 1'b0;
    bus.pcm_data  = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rd    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    in_frame      = mk_in(16'h8000, 20'h0, 20'h0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst sdata_out", 32'(sdo), 0);
    chk("rst sync", 32'(sync), 0);
    chk("rst reset_b", 32'(rstb), 0);
    chk("rst strobe", 32'(fs), 0);
    chk("rst codec_ready", 32'(cready), 0);
    chk("rst underrun", 32'(ucnt), 0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst pcm_ready", 32'(bus.pcm_ready), 1);
    chk("rst cmd_ready", 32'(bus.cmd_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_b release", 32'(rstb), 1);

    // three empty frames
    wait_strobe("strobe f1");
    capture();
    chk("f1 sync shape", 32'(sync_ok), 1);
    chk("codec_ready", 32'(cready), 1);
    capture();
    chk("underrun 3", 32'(ucnt), 3);
    capture();
    chk("f3 tag", 32'(tag_of(fr)), 32'h8000);
    chk("f3 body zero", 32'(fr[16:255] == '0), 1);

    // one stereo sample
    bus.pcm_data  = {16'hABCD, 16'h1234};
    bus.pcm_valid = 1'b1;
    @(negedge clk);
    bus.pcm_valid = 1'b0;
    wait_strobe("strobe f5");
    chk("underrun 4", 32'(ucnt), 4);
    capture();
    chk("f5 tag", 32'(tag_of(fr)), 32'h9800);
    chk("f5 slot3", 32'(slot_of(fr, 3)), 32'h12340);
    chk("f5 slot4", 32'(slot_of(fr, 4)), 32'hABCD0);

    // register write
    bus.cmd_valid = 1'b1;
    bus.cmd_rd    = 1'b0;
    bus.cmd_addr  = 7'h18;
    bus.cmd_data  = 16'h0808;
    @(negedge clk);
    chk("cmd held", 32'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b0;
    wait_strobe("strobe f7");
    chk("cmd_ready after load", 32'(bus.cmd_ready), 1);
    capture();
    chk("f7 tag", 32'(tag_of(fr)), 32'hE000);
    chk("f7 slot1", 32'(slot_of(fr, 1)), 32'h18000);
    chk("f7 slot2", 32'(slot_of(fr, 2)), 32'h08080);

    // register read
    bus.cmd_valid = 1'b1;
    bus.cmd_rd    = 1'b1;
    bus.cmd_addr  = 7'h26;
    bus.cmd_data  = 16'hFFFF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_strobe("strobe f9");
    capture();
    chk("f9 tag", 32'(tag_of(fr)), 32'hE000);
    chk("f9 slot1", 32'(slot_of(fr, 1)), 32'hA6000);
    chk("f9 slot2", 32'(slot_of(fr, 2)), 32'h0);

    // fill the 4-deep FIFO with six pushes
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ready before push %0d", i),
          32'(bus.pcm_ready), (i < 4) ? 32'd1 : 32'd0);
      bus.pcm_data  = {16'(16'h00A0 + i), 16'(16'h0010 + i)};
      bus.pcm_valid = 1'b1;
      @(negedge clk);
    end
    // hold a push across the load so it meets the pop at full
    bus.pcm_data = {16'h6666, 16'h5555};
    wait_strobe("strobe f11");
    chk("full after push+pop", 32'(bus.pcm_ready), 0);
    bus.pcm_valid = 1'b0;
    capture();
    chk("f11 slot3", 32'(slot_of(fr, 3)), 32'h00100);
    chk("f11 slot4", 32'(slot_of(fr, 4)), 32'h00A00);
    chk("ready after pop", 32'(bus.pcm_ready), 1);
    wait_strobe("strobe f13");
    wait_strobe("strobe f14");
    wait_strobe("strobe f15");
    capture();
    chk("f15 tag", 32'(tag_of(fr)), 32'h9800);
    chk("f15 slot3", 32'(slot_of(fr, 3)), 32'h55550);
    chk("f15 slot4", 32'(slot_of(fr, 4)), 32'h66660);

    // codec status frame
    in_frame = mk_in(16'hE000, 20'h26000, 20'h000F0);
    capture();
    in_frame = mk_in(16'h8000, 20'h0, 20'h0);
    chk("f16 tag underrun", 32'(tag_of(fr)), 32'h8000);
`ifdef AC97_STATUS_CAPTURE_EN
    chk("rsp pulses", 32'(rsp_pulses), 1);
    chk("rsp_addr", 32'(rsp_a), 32'h26);
    chk("rsp_data", 32'(rsp_d), 32'h000F);
`else
    chk("rsp pulses", 32'(rsp_pulses), 0);
    chk("rsp_addr tied", 32'(bus.rsp_addr), 0);
    chk("rsp_data tied", 32'(bus.rsp_data), 0);
`endif

    // reset in the middle of a frame with work pending
    bus.pcm_data  = {16'h7777, 16'h3333};
    bus.pcm_valid = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rd    = 1'b0;
    bus.cmd_addr  = 7'h02;
    bus.cmd_data  = 16'h1111;
    @(negedge clk);
    bus.pcm_valid = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst sdata_out", 32'(sdo), 0);
    chk("mid rst sync", 32'(sync), 0);
    chk("mid rst strobe", 32'(fs), 0);
    chk("mid rst codec_ready", 32'(cready), 0);
    chk("mid rst underrun", 32'(ucnt), 0);
    chk("mid rst reset_b", 32'(rstb), 0);
    chk("mid rst cmd_ready", 32'(bus.cmd_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst reset_b release", 32'(rstb), 1);
    wait_strobe("strobe after rst");
    chk("underrun after rst", 32'(ucnt), 1);
    capture();
    chk("frame after rst tag", 32'(tag_of(fr)), 32'h8000);
    chk("frame after rst body", 32'(fr[16:255] == '0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
